// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the program loader
package program_loader_pkg;

    localparam int PROG_WORDS     = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE
    } loader_state_t;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte-stream input and program-memory write port of the loader
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = $clog2(PROG_WORDS)
);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_write_enable,
        output mem_address,
        output mem_write_data
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_write_enable,
        input  mem_address,
        input  mem_write_data
    );

endinterface

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - gathers four little-endian bytes into a 32-bit word
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  count_q, count_d;
    logic [31:0] word_q, word_d;

    // Word with the incoming byte dropped into its lane; complete when word_ready_o is high.
    always_comb begin
        word_d                         = word_q;
        word_d[{count_q, 3'b000} +: 8] = byte_i;
        count_d                        = count_q + 2'd1;
    end

    assign word_o       = word_d;
    assign word_ready_o = accept_i && (count_q == LAST_BYTE);

    // Byte counter wraps after the fourth byte so the next word starts in lane 0.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            count_q <= '0;
            word_q  <= '0;
        end else if (accept_i) begin
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program image loader; PROGRAM_LOADER_CHECKSUM_EN adds a trailer checksum
module program_loader
    import program_loader_pkg::*;
#(
    parameter int WORDS  = PROG_WORDS,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [ADDR_W:0]  num_words_i,
    program_loader_if.master bus,
    output logic             core_hold_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    localparam logic [ADDR_W:0]   WORDS_N = (ADDR_W+1)'(WORDS);
    localparam logic [ADDR_W:0]   ONE_N   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_IDX = ADDR_W'(1);

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   num_words_q, num_words_d, num_clamped;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rx_ready, accept, last_word;
    logic              asm_clear, word_ready;
    logic [31:0]       asm_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
    logic              error_q, error_d;
`endif

    assign num_clamped = (num_words_i > WORDS_N) ? WORDS_N : num_words_i;
    assign last_word   = ({1'b0, word_idx_q} == (num_words_q - ONE_N));
    // Reset masks the handshake so no byte is consumed in the reset cycle.
    assign rx_ready    = !reset_i && (state_q == RECV || state_q == CHECK);
    assign accept      = rx_ready && bus.rx_valid;

    byte_assembler u_byte_assembler (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (asm_clear),
        .accept_i     (accept),
        .byte_i       (bus.rx_data),
        .word_o       (asm_word),
        .word_ready_o (word_ready)
    );

    // Next-state logic: receive four bytes, strobe one write, repeat until the last word.
    always_comb begin
        state_d     = state_q;
        num_words_d = num_words_q;
        word_idx_d  = word_idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        asm_clear   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
        error_d     = error_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    num_words_d = num_clamped;
                    word_idx_d  = '0;
                    asm_clear   = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d       = '0;
                    error_d     = 1'b0;
`endif
                    state_d     = (num_clamped == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (word_ready) begin
                    wdata_d = asm_word;
                    addr_d  = word_idx_q;
                    state_d = WRITE;
                end
            end
            WRITE: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                sum_d = sum_q + wdata_q;
`endif
                if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    word_idx_d = word_idx_q + ONE_IDX;
                    state_d    = RECV;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (word_ready) begin
                    error_d = (asm_word != sum_q);
                    state_d = DONE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            num_words_q <= '0;
            word_idx_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            num_words_q <= num_words_d;
            word_idx_q  <= word_idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running word sum and the sticky mismatch flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sum_q   <= '0;
            error_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            error_q <= error_d;
        end
    end
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    assign bus.rx_ready         = rx_ready;
    assign bus.mem_write_enable = !reset_i && (state_q == WRITE);
    assign bus.mem_address      = addr_q;
    assign bus.mem_write_data   = wdata_q;
    assign core_hold_o          = (state_q != DONE);
    assign busy_o               = (state_q != IDLE) && (state_q != DONE);
    assign done_o               = (state_q == DONE);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int ADDR_W  = 5;
    localparam int WORDS_C = PROG_WORDS;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int n;
        int mode;
        int exp_writes;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              start_i = 1'b0;
    logic [ADDR_W:0]   num_words_i = '0;
    logic              core_hold_o, busy_o, done_o, error_o;

    program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    program_loader dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .num_words_i (num_words_i),
        .bus         (bus),
        .core_hold_o (core_hold_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                wr_cyc[$];

    always @(posedge clk) cyc++;

    // Program memory write port: one entry per cycle the strobe is high.
    always @(negedge clk) begin
        if (bus.mem_write_enable === 1'b1) begin
            wr_addr.push_back(bus.mem_address);
            wr_data.push_back(bus.mem_write_data);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int c = 0; c < 16 && !acc; c++) begin
            acc = (bus.rx_ready === 1'b1);
            step();
        end
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        check("rx_accept", 64'(acc), 64'd1);
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, bus.rx_ready, 0);
        check({tag, "_mem_we"}, bus.mem_write_enable, 0);
        check({tag, "_mem_addr"}, bus.mem_address, 0);
        check({tag, "_mem_data"}, bus.mem_write_data, 0);
        check({tag, "_core_hold"}, core_hold_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_error"}, error_o, 0);
    endtask

    // Full load: expected words come from grouping the byte list in fours, little-endian first.
    task automatic do_load(input int n, input int mode, input bq_t bytes, input bit bad_sum,
                           input int glitch_at, input int exp_writes);
        int          k;
        logic [31:0] words[$];
        logic [31:0] sum, trailer;
        bq_t         stream;
        bit          exp_err;
        k   = (n > WORDS_C) ? WORDS_C : n;
        sum = 32'd0;
        for (int i = 0; i < k; i++) begin
            logic [31:0] w;
            w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
            words.push_back(w);
            sum = sum + w;
            for (int j = 0; j < 4; j++) stream.push_back(bytes[4*i+j]);
        end
        exp_err = 1'b0;
        if (CSUM && k > 0) begin
            trailer = bad_sum ? sum + 32'd1 : sum;
            for (int j = 0; j < 4; j++) stream.push_back(trailer[8*j +: 8]);
            exp_err = bad_sum;
        end

        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        start_i     = 1'b1;
        num_words_i = 6'(n);
        step();
        start_i     = 1'b0;
        if (k > 0) check("start_to_recv", {busy_o, bus.rx_ready, core_hold_o, done_o}, 4'b1110);
        else       check("zero_done_next_cycle", {done_o, core_hold_o, busy_o}, 3'b100);

        for (int i = 0; i < stream.size(); i++) begin
            if (mode == 1)      idle(1);
            else if (mode == 2) idle(int'($urandom_range(0, 2)));
            if (i == glitch_at) begin
                start_i     = 1'b1;
                num_words_i = 6'd5;
                step();
                start_i     = 1'b0;
            end
            send_byte(stream[i]);
        end

        for (int c = 0; c < 20 && done_o !== 1'b1; c++) step();
        check("done", done_o, 1);
        check("core_hold_released", core_hold_o, 0);
        check("busy_low", busy_o, 0);
        check("error", error_o, 64'(exp_err));
        check("write_count", wr_addr.size(), exp_writes);
        for (int i = 0; i < wr_addr.size() && i < k; i++) begin
            check("write_addr", wr_addr[i], i);
            check("write_data", wr_data[i], words[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        bq_t  b;

        vecs[0] = '{n: 1,  mode: 0, exp_writes: 1};
        vecs[1] = '{n: 2,  mode: 1, exp_writes: 2};
        vecs[2] = '{n: 5,  mode: 2, exp_writes: 5};
        vecs[3] = '{n: 0,  mode: 0, exp_writes: 0};
        vecs[4] = '{n: 40, mode: 0, exp_writes: 32};
        vecs[5] = '{n: 33, mode: 2, exp_writes: 32};
        vecs[6] = '{n: 32, mode: 1, exp_writes: 32};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) step();
        reset_i = 1'b0;
        step();
        check_reset_vals("reset");

        // Two words, continuous valid, writes five cycles apart.
        b = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_load(2, 0, b, 1'b0, -1, 2);
        if (wr_cyc.size() == 2) check("write_spacing", wr_cyc[1] - wr_cyc[0], 5);

        // Same image with valid toggling.
        do_load(2, 1, b, 1'b0, -1, 2);

        for (int i = 0; i < 7; i++)
            do_load(vecs[i].n, vecs[i].mode, rand_bytes(4 * WORDS_C), 1'b0, -1, vecs[i].exp_writes);

        // Reset after six bytes of a three-word load, then a clean one-word load.
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        start_i     = 1'b1;
        num_words_i = 6'd3;
        step();
        start_i     = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check_reset_vals("reset_mid_load");
        check("reset_mid_load_writes", wr_addr.size(), 1);
        b = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_load(1, 0, b, 1'b0, -1, 1);

        // Reset landing in the WRITE cycle must suppress the strobe.
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        start_i     = 1'b1;
        num_words_i = 6'd1;
        step();
        start_i     = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(1, 255)));
        reset_i = 1'b1;
        #1;
        check("no_strobe_in_reset", bus.mem_write_enable, 0);
        step();
        reset_i = 1'b0;
        check("reset_in_write_count", wr_addr.size(), 0);
        check_reset_vals("reset_in_write");

        // start pulsed mid-receive is ignored.
        do_load(2, 0, rand_bytes(8), 1'b0, 2, 2);

        // Checksum trailer good and bad (error stays low without the checksum build).
        b = {8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        do_load(2, 0, b, 1'b0, -1, 2);
        do_load(2, 0, b, 1'b1, -1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
